// File: rtl/flap_input_ctrl.sv
// Keycode-to-game-event front end: start pulse, frame-aligned flap request, hold-off and flap counter.
// Optional macro FLAP_AUTOREPEAT_EN re-arms a held flap key whenever the hold-off has expired.
module flap_input_ctrl #(
  parameter logic [7:0]  FLAP_KEY       = 8'h2C,
  parameter logic [7:0]  START_KEY      = 8'h16,
  parameter int unsigned HOLDOFF_FRAMES = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode,
  input  logic       frame_clk,
  input  logic       game_active,
  output logic       start_pulse,
  output logic       flap_frame,
  output logic       flap_busy,
  output logic [7:0] flap_count
);

  typedef enum logic {KS_IDLE, KS_DOWN} key_state_e;

  localparam logic [3:0] HOLDOFF_INIT = 4'(HOLDOFF_FRAMES);

  key_state_e state_q, state_d;
  logic [7:0] kc_q, kc_d;
  logic       fs_sync1_q, fs_sync1_d;
  logic       fs_sync2_q, fs_sync2_d;
  logic       fs_prev_q, fs_prev_d;
  logic       frame_tick_q, frame_tick_d;
  logic       start_seen_q, start_seen_d;
  logic       start_pulse_q, start_pulse_d;
  logic       armed_q, armed_d;
  logic [3:0] holdoff_q, holdoff_d;
  logic       flap_frame_q, flap_frame_d;
  logic       flap_busy_q, flap_busy_d;
  logic [7:0] flap_count_q, flap_count_d;

  logic flap_key_hit;
  logic start_key_hit;
  logic arm_req;
  logic accept;

  always_comb begin
    kc_d         = keycode;
    fs_sync1_d   = frame_clk;
    fs_sync2_d   = fs_sync1_q;
    fs_prev_d    = fs_sync2_q;
    frame_tick_d = fs_sync2_q & ~fs_prev_q;

    flap_key_hit  = (kc_q == FLAP_KEY);
    start_key_hit = (kc_q == START_KEY);
    start_seen_d  = start_key_hit;
    start_pulse_d = start_key_hit & ~start_seen_q;

    // Only the IDLE->DOWN transition arms, so a held key cannot queue repeated flaps.
    state_d = state_q;
    arm_req = 1'b0;
    case (state_q)
      KS_IDLE: begin
        if (flap_key_hit) begin
          arm_req = 1'b1;
          state_d = KS_DOWN;
        end
      end
      KS_DOWN: begin
        if (!flap_key_hit) begin
          state_d = KS_IDLE;
        end
`ifdef FLAP_AUTOREPEAT_EN
        else if ((holdoff_q == 4'd0) && !armed_q) begin
          arm_req = 1'b1;
        end
`endif
      end
      default: state_d = KS_IDLE;
    endcase

    armed_d      = armed_q | arm_req;
    holdoff_d    = holdoff_q;
    flap_frame_d = flap_frame_q;
    flap_count_d = flap_count_q;
    accept       = frame_tick_q & armed_q & (holdoff_q == 4'd0) & game_active;

    // The tick sees the pre-edge armed value, so an arm landing on the tick edge waits a frame.
    if (frame_tick_q) begin
      if (accept) begin
        flap_frame_d = 1'b1;
        armed_d      = 1'b0;
        holdoff_d    = HOLDOFF_INIT;
        if (flap_count_q != 8'hFF) begin
          flap_count_d = flap_count_q + 8'd1;
        end
      end else begin
        flap_frame_d = 1'b0;
        if (holdoff_q != 4'd0) begin
          holdoff_d = holdoff_q - 4'd1;
        end
      end
    end

    if (!game_active) begin
      armed_d = 1'b0;
    end

    flap_busy_d = (holdoff_d != 4'd0);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= KS_IDLE;
      kc_q          <= 8'd0;
      fs_sync1_q    <= 1'b0;
      fs_sync2_q    <= 1'b0;
      fs_prev_q     <= 1'b0;
      frame_tick_q  <= 1'b0;
      start_seen_q  <= 1'b0;
      start_pulse_q <= 1'b0;
      armed_q       <= 1'b0;
      holdoff_q     <= 4'd0;
      flap_frame_q  <= 1'b0;
      flap_busy_q   <= 1'b0;
      flap_count_q  <= 8'd0;
    end else begin
      state_q       <= state_d;
      kc_q          <= kc_d;
      fs_sync1_q    <= fs_sync1_d;
      fs_sync2_q    <= fs_sync2_d;
      fs_prev_q     <= fs_prev_d;
      frame_tick_q  <= frame_tick_d;
      start_seen_q  <= start_seen_d;
      start_pulse_q <= start_pulse_d;
      armed_q       <= armed_d;
      holdoff_q     <= holdoff_d;
      flap_frame_q  <= flap_frame_d;
      flap_busy_q   <= flap_busy_d;
      flap_count_q  <= flap_count_d;
    end
  end

  assign start_pulse = start_pulse_q;
  assign flap_frame  = flap_frame_q;
  assign flap_busy   = flap_busy_q;
  assign flap_count  = flap_count_q;

endmodule

// File: tb/tb_flap_input_ctrl.sv
// Directed self-checking bench for flap_input_ctrl with HOLDOFF_FRAMES = 4.
// The autorepeat section expects the behaviour selected by FLAP_AUTOREPEAT_EN.
module tb_flap_input_ctrl;

  logic       Clk;
  logic       Reset_n;
  logic [7:0] keycode;
  logic       frame_clk;
  logic       game_active;
  logic       start_pulse;
  logic       flap_frame;
  logic       flap_busy;
  logic [7:0] flap_count;

  int checksTotal;
  int checksPassed;
  int pulseCount;

  flap_input_ctrl #(
    .FLAP_KEY(8'h2C),
    .START_KEY(8'h16),
    .HOLDOFF_FRAMES(4)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .keycode(keycode),
    .frame_clk(frame_clk),
    .game_active(game_active),
    .start_pulse(start_pulse),
    .flap_frame(flap_frame),
    .flap_busy(flap_busy),
    .flap_count(flap_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checksTotal++;
    if (observed == expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] code, input int cycles);
    @(negedge Clk);
    keycode = code;
    repeat (cycles) @(negedge Clk);
  endtask

  task automatic tapKey(input logic [7:0] code);
    applyStimulus(code, 3);
    applyStimulus(8'h00, 3);
  endtask

  // One full VGA_VS period: 8 cycles high, 8 low; the tick is consumed early in the high phase.
  task automatic doFrame();
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (8) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (8) @(negedge Clk);
  endtask

  task automatic doReset();
    @(negedge Clk);
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    checksTotal  = 0;
    checksPassed = 0;
    Reset_n      = 1'b0;
    keycode      = 8'h00;
    frame_clk    = 1'b0;
    game_active  = 1'b0;

    #1;
    checkOutput("reset start_pulse", int'(start_pulse), 0);
    checkOutput("reset flap_frame", int'(flap_frame), 0);
    checkOutput("reset flap_busy", int'(flap_busy), 0);
    checkOutput("reset flap_count", int'(flap_count), 0);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Single press held across two frames gives one flap and four busy frames
    game_active = 1'b1;
    applyStimulus(8'h2C, 3);
    doFrame();
    checkOutput("t1 flap_frame", int'(flap_frame), 1);
    checkOutput("t1 flap_count", int'(flap_count), 1);
    checkOutput("t1 flap_busy", int'(flap_busy), 1);
    doFrame();
    checkOutput("t2 flap_frame", int'(flap_frame), 0);
    checkOutput("t2 flap_busy", int'(flap_busy), 1);
    applyStimulus(8'h00, 3);
    doFrame();
    checkOutput("t3 flap_busy", int'(flap_busy), 1);
    doFrame();
    checkOutput("t4 flap_busy", int'(flap_busy), 1);
    doFrame();
    checkOutput("t5 flap_busy", int'(flap_busy), 0);
    checkOutput("t5 flap_count", int'(flap_count), 1);

    // Re-press during hold-off waits until tick N+5; a further press is absorbed
    tapKey(8'h2C);
    doFrame();
    checkOutput("N flap_frame", int'(flap_frame), 1);
    checkOutput("N flap_count", int'(flap_count), 2);
    tapKey(8'h2C);
    doFrame();
    checkOutput("N+1 flap_frame", int'(flap_frame), 0);
    tapKey(8'h2C);
    for (int i = 2; i <= 4; i++) begin
      doFrame();
      checkOutput($sformatf("N+%0d flap_frame", i), int'(flap_frame), 0);
    end
    doFrame();
    checkOutput("N+5 flap_frame", int'(flap_frame), 1);
    checkOutput("N+5 flap_count", int'(flap_count), 3);
    doFrame();
    checkOutput("N+6 flap_frame", int'(flap_frame), 0);
    checkOutput("N+6 flap_count", int'(flap_count), 3);
    repeat (4) doFrame();
    checkOutput("idle flap_busy", int'(flap_busy), 0);

    // Held start key with the game inactive gives exactly one start pulse
    game_active = 1'b0;
    @(negedge Clk);
    keycode = 8'h16;
    pulseCount = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (start_pulse) pulseCount++;
    end
    checkOutput("start held pulses", pulseCount, 1);
    checkOutput("start flap_frame", int'(flap_frame), 0);
    checkOutput("start flap_count", int'(flap_count), 3);
    applyStimulus(8'h00, 3);

    // Direct FLAP->START switch still produces a start pulse
    applyStimulus(8'h2C, 3);
    @(negedge Clk);
    keycode = 8'h16;
    pulseCount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (start_pulse) pulseCount++;
    end
    checkOutput("switch start pulses", pulseCount, 1);
    applyStimulus(8'h00, 3);

    // Press whose arm lands on the tick edge is taken one frame later
    game_active = 1'b1;
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (2) @(negedge Clk);
    keycode = 8'h2C;
    repeat (6) @(negedge Clk);
    frame_clk = 1'b0;
    keycode   = 8'h00;
    repeat (8) @(negedge Clk);
    checkOutput("coincident same tick", int'(flap_frame), 0);
    doFrame();
    checkOutput("coincident next tick", int'(flap_frame), 1);
    checkOutput("coincident flap_count", int'(flap_count), 4);
    repeat (5) doFrame();

    // Press while inactive is dropped
    game_active = 1'b0;
    tapKey(8'h2C);
    game_active = 1'b1;
    doFrame();
    checkOutput("inactive flap_frame", int'(flap_frame), 0);
    checkOutput("inactive flap_count", int'(flap_count), 4);

    // Reset mid-hold-off with a pending arm
    tapKey(8'h2C);
    doFrame();
    checkOutput("prereset flap_count", int'(flap_count), 5);
    doFrame();
    tapKey(8'h2C);
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    checkOutput("midreset flap_frame", int'(flap_frame), 0);
    checkOutput("midreset flap_busy", int'(flap_busy), 0);
    checkOutput("midreset flap_count", int'(flap_count), 0);
    checkOutput("midreset start_pulse", int'(start_pulse), 0);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    doFrame();
    checkOutput("postreset flap_frame 1", int'(flap_frame), 0);
    doFrame();
    checkOutput("postreset flap_frame 2", int'(flap_frame), 0);
    checkOutput("postreset flap_count", int'(flap_count), 0);

    // Flap key held for 20 frames
    applyStimulus(8'h2C, 3);
    for (int i = 1; i <= 20; i++) begin
      doFrame();
`ifdef FLAP_AUTOREPEAT_EN
      checkOutput($sformatf("held frame %0d", i), int'(flap_frame), (i % 5 == 1) ? 1 : 0);
`else
      checkOutput($sformatf("held frame %0d", i), int'(flap_frame), (i == 1) ? 1 : 0);
`endif
    end
    applyStimulus(8'h00, 3);
    repeat (5) doFrame();

    // Saturation of the flap counter
    doReset();
    for (int i = 1; i <= 300; i++) begin
      tapKey(8'h2C);
      doFrame();
      if (i == 254) checkOutput("sat count 254", int'(flap_count), 254);
      if (i == 255) checkOutput("sat count 255", int'(flap_count), 255);
      if (i == 300) begin
        checkOutput("sat flap_frame", int'(flap_frame), 1);
        checkOutput("sat count 300", int'(flap_count), 255);
      end
      repeat (4) doFrame();
    end

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/flap_input_ctrl.md
Name: flap_input_ctrl

Overview:
- Sits between the NIOS keycode PIO and the bird/statemachine stage.
- Converts the raw 8-bit keycode level into clean game events:
  - a one-cycle start pulse;
  - a flap request aligned to the frame clock (VGA_VS) that the bird physics update consumes once per frame.
- Provides edge detection, a one-deep flap buffer, a frame-counted hold-off between flaps, and a saturating flap counter for the HEX display.

Parameters:
- FLAP_KEY, 8'h2C, keycode that requests a flap (space bar).
- START_KEY, 8'h16, keycode that requests game start ('S').
- HOLDOFF_FRAMES, 4, minimum frame ticks between two accepted flaps (1..15).

Ports:
- Clk  in  1  50 MHz system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- keycode  in  8  current keycode from NIOS PIO (synchronous to Clk).
- frame_clk  in  1  VGA_VS, asynchronous to Clk.
- game_active  in  1  high while the statemachine is in the play state.
- start_pulse  out  1  one Clk-cycle pulse on a new START_KEY press.
- flap_frame  out  1  high for exactly one frame period when a flap is accepted.
- flap_busy  out  1  high while the hold-off counter is nonzero.
- flap_count  out  8  number of accepted flaps, saturating at 255.

Behaviour:
- Reset (async assert, sync deassert by design): all outputs 0, FSM in KS_IDLE, armed=0, holdoff=0, sync flops 0.
- Input registering:
  - keycode is registered once (kc_q).
  - frame_clk passes through a 2-FF synchronizer followed by a rising-edge detector, giving frame_tick (one Clk cycle).
  - Latency from VGA_VS rise to frame_tick is 3 Clk cycles.
- Flap key FSM:
  - KS_IDLE: if kc_q==FLAP_KEY, set armed (effective next cycle) and go to KS_DOWN.
  - KS_DOWN: if kc_q!=FLAP_KEY, go to KS_IDLE.
  - Holding the key generates no further arms.
- Armed buffer:
  - One deep. A new press while armed=1 is absorbed; no second flap is queued.
- On each frame_tick:
  - If armed && holdoff==0 && game_active:
    - flap_frame<=1;
    - armed<=0;
    - holdoff<=HOLDOFF_FRAMES;
    - flap_count<=flap_count+1, saturating at 255.
  - Otherwise:
    - flap_frame<=0;
    - if holdoff!=0, holdoff<=holdoff-1.
  - flap_frame changes only on frame_tick, so it is held for the full frame.
- Hold-off interaction:
  - A press during hold-off stays armed.
  - It is accepted on the first tick where holdoff==0. Because the decrement and the check happen in the same tick, a flap is accepted at tick N and the next possible flap at tick N+HOLDOFF_FRAMES+1.
- flap_busy = (holdoff!=0), driven from a register.
- game_active low:
  - armed is cleared every cycle and no flap is accepted.
  - holdoff keeps counting down.
  - flap_count is not cleared.
- Simultaneous press and frame_tick in the same cycle: the arm is not visible to that tick; the flap is accepted at the next tick.
- start_pulse:
  - Rising edge of (kc_q==START_KEY), registered, one Clk cycle, independent of game_active.
  - A held key gives a single pulse.
- Keycode switching directly FLAP_KEY→START_KEY: FSM returns to KS_IDLE and start_pulse fires; both edges are handled independently.
- Reset mid-frame or mid-hold-off: everything returns to reset values immediately; a pending flap is lost.

Optional Feature:
- Macro FLAP_AUTOREPEAT_EN.
- When defined: in KS_DOWN, with the key still held and holdoff==0 and armed==0, armed is re-set. A held key therefore flaps every HOLDOFF_FRAMES+1 frames.
- When undefined: only a new press (KS_IDLE→KS_DOWN) arms.
- All other behaviour is identical in both builds.

Test Plan:
- Reset_n=0 mid-operation with armed=1 and holdoff=3 → all outputs 0 immediately, no flap after release of reset.
- game_active=1, keycode=8'h2C for 2 frames then 8'h00 → exactly one flap_frame high for one full frame at the first tick after the press; flap_count=1; flap_busy high for 4 subsequent ticks.
- Press FLAP_KEY, release, press again within 2 frames of acceptance → second flap accepted at tick N+5; flap_count=2; a third press while armed adds nothing.
- keycode=8'h16 held 100 cycles with game_active=0 → exactly one start_pulse (1 Clk); no flap_frame; flap_count unchanged.
- Press coincident with frame_tick → flap accepted at the following tick, not the current one. game_active=0 during a press → no flap, and armed is dropped.
- 300 accepted flaps → flap_count saturates at 255. With FLAP_AUTOREPEAT_EN defined, FLAP_KEY held 20 frames → flaps at ticks 1, 6, 11, 16.
